// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared types and constants for the two-requester LIFO stack controller.
// Build option: define STACK_CTRL_RR_EN for round-robin arbitration (fixed r0 priority otherwise).
package stack_ctrl_pkg;

  // Controller FSM states; one stack operation in flight at a time.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Requester operation encoding.
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  // Requester identifier: r0 = CPU call/return unit, r1 = push/pop instruction path.
  typedef logic id_t;
  localparam id_t ID_R0 = 1'b0;
  localparam id_t ID_R1 = 1'b1;

endpackage

// File: rtl/stack_arb.sv
// stack_arb: 2-way arbiter for the stack controller.
// Build option: STACK_CTRL_RR_EN selects round-robin (tie goes to the requester not granted
// last; pointer resets to r1 so r0 wins the first tie). Undefined: r0 always wins ties.
// Ports:
//   clk, rst  clock and synchronous active-high reset (pointer only)
//   req       request vector, bit i = requester i
//   advance   a grant was taken this cycle; updates the round-robin pointer
//   gnt_id    combinational winner id, meaningful only while |req
module stack_arb
  import stack_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output id_t        gnt_id
);

`ifdef STACK_CTRL_RR_EN
  id_t last_q;

  // Last-granted pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ID_R1;
    end else if (advance) begin
      last_q <= gnt_id;
    end
  end

  // Tie goes to whoever was not granted last.
  always_comb begin
    if (req == 2'b11) begin
      gnt_id = (last_q == ID_R0) ? ID_R1 : ID_R0;
    end else begin
      gnt_id = req[0] ? ID_R0 : ID_R1;
    end
  end
`else
  // Fixed priority keeps no state.
  logic unused_rr;
  assign unused_rr = ^{clk, rst, advance};

  always_comb begin
    gnt_id = req[0] ? ID_R0 : ID_R1;
  end
`endif

endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: two-requester controller for a DATA_W-bit, DEPTH-entry LIFO stack.
// Arbitrates push/pop requests, drives the stack enables/data, keeps a shadow occupancy
// count for full/empty, rejects overflow/underflow and routes popped data to the owner.
// Build option: STACK_CTRL_RR_EN enables round-robin arbitration (see stack_arb).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rN_req/op/wdata          requester N request (held until gnt), 0=push 1=pop, push data
//   rN_gnt/err               1-cycle accept pulse; err marks overflow/underflow
//   rN_rvalid/rdata          1-cycle pop response pulse; rdata held until next response
//   stk_write_en/read_en     stack enables (never both)
//   stk_data_in/data_out     stack data; data_out valid the cycle after read_en
//   count/full/empty         registered occupancy
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_op,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_err,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_op,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_err,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              stk_write_en,
  output logic              stk_read_en,
  output logic [DATA_W-1:0] stk_data_in,
  input  logic [DATA_W-1:0] stk_data_out,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  state_e            state_q, state_nxt;
  id_t               win_id, id_q;
  logic              win_op;
  logic [DATA_W-1:0] win_wdata;
  logic              advance;
  logic [1:0]        gnt_q, gnt_nxt, err_q, err_nxt, rvalid_q, rvalid_nxt;
  logic              we_nxt, re_nxt;
  logic [CNT_W-1:0]  count_nxt;

  stack_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({r1_req, r0_req}),
    .advance (advance),
    .gnt_id  (win_id)
  );

  assign win_op    = (win_id == ID_R1) ? r1_op    : r0_op;
  assign win_wdata = (win_id == ID_R1) ? r1_wdata : r0_wdata;

  assign r0_gnt    = gnt_q[0];
  assign r1_gnt    = gnt_q[1];
  assign r0_err    = err_q[0];
  assign r1_err    = err_q[1];
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];

  // Next state and next-cycle outputs; ISSUE-cycle pulses are decided while still in IDLE
  // so they leave a register, using full/empty which already reflect the last ISSUE.
  always_comb begin
    state_nxt  = state_q;
    advance    = 1'b0;
    gnt_nxt    = '0;
    err_nxt    = '0;
    rvalid_nxt = '0;
    we_nxt     = 1'b0;
    re_nxt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          advance          = 1'b1;
          state_nxt        = ISSUE;
          gnt_nxt[win_id]  = 1'b1;
          if (win_op == OP_PUSH) begin
            if (full) err_nxt[win_id] = 1'b1;
            else      we_nxt          = 1'b1;
          end else begin
            if (empty) err_nxt[win_id] = 1'b1;
            else       re_nxt          = 1'b1;
          end
        end
      end
      ISSUE: state_nxt = stk_read_en ? WAIT : IDLE;
      WAIT: begin
        state_nxt        = RESP;
        rvalid_nxt[id_q] = 1'b1;
      end
      RESP: state_nxt = IDLE;
    endcase
  end

  // State and control-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      err_q        <= '0;
      rvalid_q     <= '0;
      stk_write_en <= 1'b0;
      stk_read_en  <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      gnt_q        <= gnt_nxt;
      err_q        <= err_nxt;
      rvalid_q     <= rvalid_nxt;
      stk_write_en <= we_nxt;
      stk_read_en  <= re_nxt;
    end
  end

  // Occupancy follows the enables actually issued to the stack.
  always_comb begin
    count_nxt = count;
    if (stk_write_en)     count_nxt = count + CNT_W'(1);
    else if (stk_read_en) count_nxt = count - CNT_W'(1);
  end

  // Datapath: winner latch, pop data capture, occupancy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q        <= ID_R0;
      stk_data_in <= '0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else begin
      if (advance) begin
        id_q        <= win_id;
        stk_data_in <= win_wdata;
      end
      if (state_q == WAIT) begin
        if (id_q == ID_R1) r1_rdata <= stk_data_out;
        else               r0_rdata <= stk_data_out;
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule
